// File: rtl/comparator_serial_n_if.sv
// Handshake and operand bundle for the MSB-first serial magnitude comparator.
interface comparator_serial_n_if #(
    parameter int WIDTH = 8
);
    logic             in_start;
    logic             in_signed;
    logic [WIDTH-1:0] in_A;
    logic [WIDTH-1:0] in_B;
    logic             out_busy;
    logic             out_done;
    logic [2:0]       out_C;

    modport master (
        output in_start, in_signed, in_A, in_B,
        input  out_busy, out_done, out_C
    );

    modport slave (
        input  in_start, in_signed, in_A, in_B,
        output out_busy, out_done, out_C
    );
endinterface

// File: rtl/comparator_serial_n.sv
// Serial comparator: scans one captured bit pair per clock, MSB first, stops on the first difference.
// States: IDLE wait for start | SCAN compare bit at idx_q | DONE one-cycle result pulse.
module comparator_serial_n #(
    parameter int WIDTH = 8
) (
    input  logic                  in_clk,
    input  logic                  in_rst,
    comparator_serial_n_if.slave  bus
);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sgn_q, sgn_d;
    logic [2:0]       c_q, c_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             bit_a, bit_b, a_gt;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        c_d     = c_q;
        done_d  = 1'b0;
        bit_a   = a_q[idx_q];
        bit_b   = b_q[idx_q];
        // A sign bit of 1 means the smaller value, so the MSB decision flips in signed mode.
        a_gt    = bit_a ^ (sgn_q && (idx_q == IDX_MSB));
        case (state_q)
            S_IDLE: begin
                if (bus.in_start) begin
                    a_d     = bus.in_A;
                    b_d     = bus.in_B;
                    sgn_d   = bus.in_signed;
                    idx_d   = IDX_MSB;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (bit_a != bit_b) begin
                    c_d     = a_gt ? 3'b100 : 3'b001;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (idx_q == '0) begin
                    c_d     = 3'b010;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q - IDX_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            c_q     <= 3'b000;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            c_q     <= c_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.out_busy = busy_q;
    assign bus.out_done = done_q;
    assign bus.out_C    = c_q;
endmodule
